wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 14 +
 rtl/wb_arbiter_pick.sv | 34 +++
 rtl/wb_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the Wishbone arbiter: FSM state encoding and
// default sizing constants.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_MASTERS    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/wb_arbiter_pick.sv
// arb_pick: combinational winner selection. Searches the request vector
// starting at ptr_i+1 and wrapping modulo N; the first requester found wins.
// With ptr_i = N-1 the search starts at index 0, i.e. fixed priority.
module arb_pick
  import wb_arbiter_pkg::*;
#(
  parameter int N     = DEF_NUM_MASTERS,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  // Rotating first-set search producing a one-hot grant.
  always_comb begin
    logic             found;
    logic [31:0]      idx;
    logic [IDX_W-1:0] sel;
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      idx = (32'(ptr_i) + 32'(i) + 32'd1) % 32'(N);
      sel = IDX_W'(idx);
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shared Wishbone bus arbiter for the cache/MMU requesters.
// One owner at a time; the grant is held until the owner drops cyc, so
// multi-beat refills stay atomic. A stalled slave is aborted after
// TIMEOUT_CYCLES unanswered strobe cycles.
// Build option: define WB_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority (index 0 highest).
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*32-1:0] m_adr_i,
  input  logic [NUM_MASTERS*32-1:0] m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_rty_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_ptr;

  logic        own_cyc, own_stb, own_we;
  logic [31:0] own_adr, own_dat;
  logic [3:0]  own_sel;

`ifdef WB_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_idx;

  // Pointer remembers the index of the last grant; it moves on every grant.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_gnt[i]) win_idx = IDX_W'(i);
    end
    ptr_d = ptr_q;
    if (state_q == IDLE && |m_cyc_i) ptr_d = win_idx;
  end

  // Round-robin pointer register; reset so that master 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= IDX_W'(NUM_MASTERS - 1);
    else     ptr_q <= ptr_d;
  end

  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = IDX_W'(NUM_MASTERS - 1);
`endif

  arb_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i (m_cyc_i),
    .ptr_i (pick_ptr),
    .gnt_o (pick_gnt)
  );

  // Select the current owner's bus signals by the one-hot grant.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        own_cyc = m_cyc_i[i];
        own_stb = m_stb_i[i];
        own_we  = m_we_i[i];
        own_adr = m_adr_i[i*32 +: 32];
        own_dat = m_dat_i[i*32 +: 32];
        own_sel = m_sel_i[i*4 +: 4];
      end
    end
  end

  // Next-state, grant, timeout counter and bus outputs.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|m_cyc_i) begin
          grant_d = pick_gnt;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_cyc_o = own_cyc;
        s_stb_o = own_stb;
        s_we_o  = own_we;
        s_adr_o = own_adr;
        s_dat_o = own_dat;
        s_sel_o = own_sel;
        if (!own_cyc) begin
          // Owner released the bus; arbitration resumes from IDLE.
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else begin
          m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
          m_err_o = grant_q & {NUM_MASTERS{s_err_i}};
          m_rty_o = grant_q & {NUM_MASTERS{s_rty_i}};
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            m_err_o = grant_q;
            state_d = ABORT;
            cnt_d   = '0;
          end else if (s_ack_i || s_err_i || s_rty_i || !own_stb) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ABORT: begin
        // One cycle with cyc low terminates the stalled slave cycle.
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, grant and timeout counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o = grant_q;
  assign m_dat_o = s_dat_i;

endmodule
